// File: rtl/svf_output_stage.sv
// Output stage for the state-variable filter: captures the filter taps, mixes them with saturation,
// applies master volume and drives a double-buffered 8-bit PWM stream.
module svf_output_stage #(
  parameter bit          ENABLE_DIRECT = 1'b1,
  parameter logic [7:0]  RESET_DUTY    = 8'h80
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic signed [7:0] hp_in,
  input  logic signed [7:0] bp_in,
  input  logic signed [7:0] lp_in,
  input  logic signed [7:0] direct_in,
  input  logic [2:0]        mode,
  input  logic [3:0]        vol,
  output logic signed [7:0] level_out,
  output logic              level_valid,
  output logic              pwm_out,
  output logic [7:0]        drop_cnt
);

  logic              r_s1_valid;
  logic signed [7:0] r_s1_hp;
  logic signed [7:0] r_s1_bp;
  logic signed [7:0] r_s1_lp;
  logic signed [7:0] r_s1_dir;
  logic [2:0]        r_s1_mode;
  logic [3:0]        r_s1_vol;

  logic              r_s2_valid;
  logic signed [7:0] r_s2_mix;
  logic [3:0]        r_s2_vol;

  logic signed [7:0] r_level;
  logic              r_level_valid;

  logic [7:0]        r_pwm_cnt;
  logic [7:0]        r_duty_pending;
  logic [7:0]        r_duty_active;
  logic              r_pending_fresh;
  logic              r_pwm_out;
  logic [7:0]        r_drop_cnt;

  logic signed [9:0]  w_sum;
  logic signed [7:0]  w_sat;
  logic signed [11:0] w_mix_ext;
  logic signed [11:0] w_vol_ext;
  logic signed [11:0] w_prod;
  logic signed [7:0]  w_scaled;
  logic [7:0]         w_duty_new;
  logic               w_wrap;
  logic               w_write;
  logic               w_unused_prod_lsb;

  // 10 bits holds four 8-bit signed terms (-512..508) without overflow
  always_comb begin
    w_sum = '0;
    if (r_s1_mode[2]) w_sum = w_sum + {{2{r_s1_hp[7]}}, r_s1_hp};
    if (r_s1_mode[1]) w_sum = w_sum + {{2{r_s1_bp[7]}}, r_s1_bp};
    if (r_s1_mode[0]) w_sum = w_sum + {{2{r_s1_lp[7]}}, r_s1_lp};
    if (ENABLE_DIRECT) w_sum = w_sum + {{2{r_s1_dir[7]}}, r_s1_dir};
  end

  always_comb begin
    w_sat = w_sum[7:0];
    if (w_sum > 10'sd127)       w_sat = 8'sh7F;
    else if (w_sum < -10'sd128) w_sat = 8'sh80;
  end

  // Product range -1920..1905 fits in 12 signed bits; bits [11:4] are the floor of /16
  assign w_mix_ext         = {{4{r_s2_mix[7]}}, r_s2_mix};
  assign w_vol_ext         = {8'd0, r_s2_vol};
  assign w_prod            = w_mix_ext * w_vol_ext;
  assign w_scaled          = w_prod[11:4];
  assign w_unused_prod_lsb = ^w_prod[3:0];
  assign w_duty_new        = w_scaled ^ 8'h80;

  assign w_wrap  = (r_pwm_cnt == 8'hFF);
  assign w_write = r_s2_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid      <= 1'b0;
      r_s1_hp         <= '0;
      r_s1_bp         <= '0;
      r_s1_lp         <= '0;
      r_s1_dir        <= '0;
      r_s1_mode       <= '0;
      r_s1_vol        <= '0;
      r_s2_valid      <= 1'b0;
      r_s2_mix        <= '0;
      r_s2_vol        <= '0;
      r_level         <= '0;
      r_level_valid   <= 1'b0;
      r_pwm_cnt       <= '0;
      r_duty_pending  <= RESET_DUTY;
      r_duty_active   <= RESET_DUTY;
      r_pending_fresh <= 1'b0;
      r_pwm_out       <= 1'b0;
      r_drop_cnt      <= '0;
    end else begin
      r_s1_valid <= sample_valid;
      if (sample_valid) begin
        r_s1_hp   <= hp_in;
        r_s1_bp   <= bp_in;
        r_s1_lp   <= lp_in;
        r_s1_dir  <= direct_in;
        r_s1_mode <= mode;
        r_s1_vol  <= vol;
      end

      r_s2_valid <= r_s1_valid;
      r_s2_mix   <= w_sat;
      r_s2_vol   <= r_s1_vol;

      r_level_valid <= r_s2_valid;
      if (r_s2_valid) r_level <= w_scaled;

      r_pwm_cnt <= r_pwm_cnt + 8'd1;
      r_pwm_out <= (r_pwm_cnt < r_duty_active);

      // A write landing on the wrap edge is held for the following period, so it is not a drop
      if (w_wrap) r_duty_active <= r_duty_pending;
      if (w_write) begin
        r_duty_pending  <= w_duty_new;
        r_pending_fresh <= 1'b1;
      end else if (w_wrap) begin
        r_pending_fresh <= 1'b0;
      end

      if (w_write && r_pending_fresh && !w_wrap && (r_drop_cnt != 8'hFF))
        r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign level_out   = r_level;
  assign level_valid = r_level_valid;
  assign pwm_out     = r_pwm_out;
  assign drop_cnt    = r_drop_cnt;

endmodule
